tm_prod_accumulator: RTL and testbench
======================================

Name: tm_prod_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 unsigned truncated multipliers (16-bit product bus, low columns forced to zero).
- Accumulates a frame of products into a wide saturating sum, framed by a last flag, and presents the result with a valid/ready handshake.
- Used as the MAC back-end for dot-product and error-characterisation datapaths built on the approximate multipliers.

Parameters:
- PROD_W, 16, product width from the multiplier stage.
- ACC_W, 24, accumulator/result width; must be >= PROD_W.
- CNT_W, 8, beat-counter width.
- COMP_VAL, 64, per-product bias constant; used only when TM_BIAS_COMP_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a beat.
- in_prod  input  PROD_W  unsigned product from the truncated multiplier.
- in_last  input  1  marks the final beat of a frame; qualified by in_valid.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  saturated frame sum.
- out_count  output  CNT_W  number of beats in the frame, saturating.
- out_ovf  output  1  sum saturated during this frame.

Behaviour:
- Reset: a rising edge with rst_n=0 forces state ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. The next edge with rst_n=1 behaves as the first cycle. A reset mid-frame or mid-HOLD discards all partial or pending data.
- States: ACC and HOLD.
- ACC:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready.
  - On accept: addend = zero-extended in_prod (plus COMP_VAL if the feature is enabled); acc <= min(acc+addend, 2^ACC_W-1); ovf <= ovf | (acc+addend > 2^ACC_W-1); cnt <= min(cnt+1, 2^CNT_W-1).
  - Accept with in_last=1: the beat is included. On the same edge, out_sum/out_count/out_ovf load the updated values, acc/cnt/ovf clear to 0, and the state moves to HOLD.
  - Latency: out_valid=1 in the cycle after the last beat is accepted.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum, out_count and out_ovf stay stable until out_ready=1.
  - On out_valid && out_ready: the state moves to ACC and out_valid=0 on the next cycle.
  - No same-cycle bypass: at least one bubble cycle between frames (max throughput is N+1 cycles per N-beat frame).
- in_valid with in_ready=0 is ignored; the upstream stage holds its data.
- in_last without in_valid has no effect.
- in_prod of 0 still counts as a beat.
- Saturation is sticky within a frame: once acc reaches all-ones it stays there, and further beats only advance cnt.
- Count saturation at 2^CNT_W-1 does not set ovf.
- Internal sum is computed at ACC_W+1 bits before the clamp.
- All outputs are registered. in_ready is decoded from the state register.

Optional Feature:
- Macro: TM_BIAS_COMP_EN.
- Defined: each accepted beat adds COMP_VAL in addition to in_prod. This compensates the mean truncation error of the upstream multiplier. The combined sum uses the same saturation and ovf rules.
- Not defined: addend is in_prod only. The COMP_VAL parameter is present but unused, and there is no extra adder logic.

Test Plan:
- Basic frame, feature off: beats 100, 200, 300 (last on 300), out_ready=1 -> out_valid one cycle after the third accept, out_sum=600, out_count=3, out_ovf=0; in_ready=0 for exactly one cycle.
- Same stimulus with TM_BIAS_COMP_EN and COMP_VAL=64 -> out_sum=792, out_count=3.
- Overflow: 257 beats of 0xFFFF, last on beat 257 -> out_sum=0xFFFFFF, out_ovf=1, out_count=255.
- Backpressure: single-beat frame 0x4000 with out_ready=0 for 5 cycles -> out_valid=1, out_sum=16384, out_count=1 stable; in_ready=0 and in_valid beats ignored throughout; after out_ready=1, next frame 7 (last) -> out_sum=7.
- Reset mid-frame: accept 500, 600 (no last), rst_n=0 for one cycle, then beat 5 with last -> out_sum=5, out_count=1, out_ovf=0.
- Reset in HOLD: pending result, rst_n=0 -> out_valid=0, out_sum=0, in_ready=1 on the first cycle after reset.

Source files
------------

// File: rtl/tm_prod_accumulator.sv
// Saturating frame accumulator behind the truncated 8x8 multipliers; valid/ready on both sides.
// Optional macro TM_BIAS_COMP_EN adds COMP_VAL to every accepted product (truncation-bias compensation).
module tm_prod_accumulator #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8,
  parameter int COMP_VAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_accept;
  logic [ACC_W:0]     w_addend;
  logic [ACC_W:0]     w_sum;
  logic               w_sat;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid && in_ready;

`ifdef TM_BIAS_COMP_EN
  assign w_addend = (ACC_W+1)'(in_prod) + (ACC_W+1)'(COMP_VAL);
`else
  assign w_addend = (ACC_W+1)'(in_prod);
`endif

  // One spare bit catches the carry out; clamp to all-ones when it is set.
  assign w_sum     = {1'b0, r_acc} + w_addend;
  assign w_sat     = w_sum[ACC_W];
  assign w_acc_nxt = w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_ovf_nxt = r_ovf | w_sat;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC:  if (w_accept && in_last) w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready)           w_state_nxt = ST_ACC;
      default:                          w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        // Final beat is folded in and the running state restarts for the next frame.
        r_out_sum   <= w_acc_nxt;
        r_out_count <= w_cnt_nxt;
        r_out_ovf   <= w_ovf_nxt;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tm_prod_accumulator.sv
// Directed bench for tm_prod_accumulator; expected sums account for TM_BIAS_COMP_EN.
module tb_tm_prod_accumulator;

`ifdef TM_BIAS_COMP_EN
  localparam int BIAS = 64;
`else
  localparam int BIAS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_checks = 0;
  int n_err    = 0;

  tm_prod_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8), .COMP_VAL(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: run did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p, input logic last);
    in_valid = 1'b1; in_prod = p; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_sum !== 24'd0)   begin n_err++; $display("FAIL reset_out_sum got=%0d exp=0", out_sum); end
    n_checks++; if (out_count !== 8'd0)  begin n_err++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
    n_checks++; if (out_ovf !== 1'b0)    begin n_err++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(16'd100, 1'b0);
    beat(16'd200, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_mid_valid got=%b exp=0", out_valid); end
    beat(16'd300, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_checks++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL basic_in_ready_hold got=%b exp=0", in_ready); end
    n_checks++; if (out_sum !== 24'(600 + 3*BIAS)) begin n_err++; $display("FAIL basic_sum got=%0d exp=%0d", out_sum, 600 + 3*BIAS); end
    n_checks++; if (out_count !== 8'd3) begin n_err++; $display("FAIL basic_count got=%0d exp=3", out_count); end
    n_checks++; if (out_ovf !== 1'b0)   begin n_err++; $display("FAIL basic_ovf got=%b exp=0", out_ovf); end
    step();
    n_checks++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_zero_and_stray_last();
    out_ready = 1'b1;
    beat(16'd0, 1'b0);
    in_valid = 1'b0; in_last = 1'b1; in_prod = 16'd999;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stray_last_valid got=%b exp=0", out_valid); end
    beat(16'd0, 1'b1);
    n_checks++; if (out_sum !== 24'(2*BIAS)) begin n_err++; $display("FAIL zero_sum got=%0d exp=%0d", out_sum, 2*BIAS); end
    n_checks++; if (out_count !== 8'd2) begin n_err++; $display("FAIL zero_count got=%0d exp=2", out_count); end
    step();
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) beat(16'hFFFF, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_mid_valid got=%b exp=0", out_valid); end
    beat(16'hFFFF, 1'b1);
    n_checks++; if (out_sum !== 24'hFFFFFF) begin n_err++; $display("FAIL ovf_sum got=%h exp=ffffff", out_sum); end
    n_checks++; if (out_ovf !== 1'b1)       begin n_err++; $display("FAIL ovf_flag got=%b exp=1", out_ovf); end
    n_checks++; if (out_count !== 8'd255)   begin n_err++; $display("FAIL ovf_count got=%0d exp=255", out_count); end
    step();
    // Flags must not leak into the following frame.
    beat(16'd10, 1'b1);
    n_checks++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", out_ovf); end
    n_checks++; if (out_sum !== 24'(10 + BIAS)) begin n_err++; $display("FAIL ovf_next_sum got=%0d exp=%0d", out_sum, 10 + BIAS); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(16'h4000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_prod = 16'h1234; in_last = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      n_checks++; if (out_sum !== 24'(16384 + BIAS)) begin n_err++; $display("FAIL bp_sum[%0d] got=%0d exp=%0d", i, out_sum, 16384 + BIAS); end
      n_checks++; if (out_count !== 8'd1) begin n_err++; $display("FAIL bp_count[%0d] got=%0d exp=1", i, out_count); end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    beat(16'd7, 1'b1);
    n_checks++; if (out_sum !== 24'(7 + BIAS)) begin n_err++; $display("FAIL bp_next_sum got=%0d exp=%0d", out_sum, 7 + BIAS); end
    n_checks++; if (out_count !== 8'd1) begin n_err++; $display("FAIL bp_next_count got=%0d exp=1", out_count); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    beat(16'd500, 1'b0);
    beat(16'd600, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    beat(16'd5, 1'b1);
    n_checks++; if (out_sum !== 24'(5 + BIAS)) begin n_err++; $display("FAIL rstmid_sum got=%0d exp=%0d", out_sum, 5 + BIAS); end
    n_checks++; if (out_count !== 8'd1) begin n_err++; $display("FAIL rstmid_count got=%0d exp=1", out_count); end
    n_checks++; if (out_ovf !== 1'b0)   begin n_err++; $display("FAIL rstmid_ovf got=%b exp=0", out_ovf); end
    step();
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b0;
    beat(16'd9, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rsthold_pending got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rsthold_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_sum !== 24'd0)  begin n_err++; $display("FAIL rsthold_sum got=%0d exp=0", out_sum); end
    n_checks++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rsthold_in_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_stray_last();
    test_overflow();
    test_backpressure();
    test_reset_mid_frame();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
